// File: rtl/reservoir_valve_sequencer_if.sv
// reservoir_valve_sequencer_if: sensor/request inputs and valve/status outputs of the valve sequencer.
interface reservoir_valve_sequencer_if;
    logic [2:0] s;
    logic req_fr0, req_fr1, req_fr2, req_dfr;
    logic v_fr0, v_fr1, v_fr2, v_dfr;
    logic busy, fault;
    modport master (
        output s, req_fr0, req_fr1, req_fr2, req_dfr,
        input  v_fr0, v_fr1, v_fr2, v_dfr, busy, fault
    );
    modport slave (
        input  s, req_fr0, req_fr1, req_fr2, req_dfr,
        output v_fr0, v_fr1, v_fr2, v_dfr, busy, fault
    );
endinterface

// File: rtl/reservoir_valve_sequencer.sv
// reservoir_valve_sequencer: staggered valve opening with minimum dwell and a sticky sensor fail-safe.
module reservoir_valve_sequencer #(
    parameter int STAGGER   = 4,
    parameter int MIN_ON    = 8,
    parameter int FAULT_CYC = 3
) (
    input logic clk,
    input logic resetn,
    reservoir_valve_sequencer_if.slave bus
);
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FAULT = 1'b1;
    logic [0:0] state;
    logic [3:0] t, v, cand, open_oh, close_m;
    logic [7:0] gap, inv, inv_inc;
    logic [7:0] hold [4];
    logic valid, trip;
    assign t = {bus.req_dfr, bus.req_fr2, bus.req_fr1, bus.req_fr0};
    assign cand = t & ~v;
    // isolate the lowest set candidate bit so only one valve opens per edge
    assign open_oh = (gap == 8'd0) ? (cand & (~cand + 4'd1)) : 4'd0;
    always_comb begin
        close_m = 4'd0;
        for (int i = 0; i < 4; i++) close_m[i] = v[i] & ~t[i] & (hold[i] == 8'd0);
    end
    assign valid = (bus.s == 3'b000) || (bus.s == 3'b001) || (bus.s == 3'b011) || (bus.s == 3'b111);
    assign inv_inc = inv + 8'd1;
    assign trip = !valid && (inv_inc == 8'(FAULT_CYC));
    assign bus.busy = (state == RUN) && (|cand);
    assign bus.fault = (state == FAULT);
    assign {bus.v_dfr, bus.v_fr2, bus.v_fr1, bus.v_fr0} = v;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= RUN;
            v <= 4'd0;
            gap <= 8'd0;
            inv <= 8'd0;
            for (int i = 0; i < 4; i++) hold[i] <= 8'd0;
        end else if (state == RUN) begin
            inv <= valid ? 8'd0 : inv_inc;
            if (trip) begin
                state <= FAULT;
                v <= 4'hf;
            end else begin
                v <= (v & ~close_m) | open_oh;
                gap <= (|open_oh) ? 8'(STAGGER - 1) : ((gap == 8'd0) ? 8'd0 : gap - 8'd1);
                for (int i = 0; i < 4; i++)
                    hold[i] <= open_oh[i] ? 8'(MIN_ON - 1) : ((hold[i] == 8'd0) ? 8'd0 : hold[i] - 8'd1);
            end
        end else begin
            v <= 4'hf;
        end
    end
endmodule
